// File: rtl/fft_writeback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_writeback_ctrl_if
// Description : Bundle of the read-address stream that feeds the FFT write-back
//               controller and of the write-port / status outputs it drives.
//               master : address generator side (drives start and rd_*)
//               slave  : write-back controller side (drives wr_* and status)
//               Signals:
//                 start, rd_valid, rd_addr_0/1, rd_ram_select, rd_stage
//                 wr_en_a, wr_en_b, wr_addr_0/1, wr_stage,
//                 stage_done, fft_done, busy, err
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_writeback_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr_0;
    logic [ADDR_WIDTH-1:0] rd_addr_1;
    logic                  rd_ram_select;
    logic [3:0]            rd_stage;

    logic                  wr_en_a;
    logic                  wr_en_b;
    logic [ADDR_WIDTH-1:0] wr_addr_0;
    logic [ADDR_WIDTH-1:0] wr_addr_1;
    logic [3:0]            wr_stage;
    logic                  stage_done;
    logic                  fft_done;
    logic                  busy;
    logic                  err;

    modport master (
        output start, rd_valid, rd_addr_0, rd_addr_1, rd_ram_select, rd_stage,
        input  wr_en_a, wr_en_b, wr_addr_0, wr_addr_1, wr_stage,
               stage_done, fft_done, busy, err
    );

    modport slave (
        input  start, rd_valid, rd_addr_0, rd_addr_1, rd_ram_select, rd_stage,
        output wr_en_a, wr_en_b, wr_addr_0, wr_addr_1, wr_stage,
               stage_done, fft_done, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/fft_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_writeback_ctrl
// Description : Write-back address controller for an in-place radix-2 FFT.
//               Each accepted read-address pair is delayed by BF_LATENCY
//               cycles and then written, at the same addresses, into the
//               ping-pong RAM opposite the one it was read from. Writes are
//               counted per stage and per transform; stage_done pulses on the
//               last write of each stage and fft_done rises on the last write
//               of the transform.
//               Ports:
//                 clk  - rising-edge clock
//                 rst  - synchronous active-high reset
//                 bus  - fft_writeback_ctrl_if.slave (read stream in,
//                        write ports and status out)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_writeback_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int N_STEPS    = 9,
    parameter int N_STAGES   = 10,
    parameter int BF_LATENCY = 3     // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_writeback_ctrl_if.slave  bus
);

    // Accepted-pair counter must hold N_STAGES * 2^N_STEPS (up to 15 stages).
    localparam int                   c_acc_w          = N_STEPS + 4;
    localparam int unsigned          c_total_int      = N_STAGES << N_STEPS;
    localparam logic [c_acc_w-1:0]   c_total_pairs    = c_total_int[c_acc_w-1:0];
    localparam logic [N_STEPS-1:0]   c_last_pair      = '1;
    localparam int unsigned          c_last_stage_int = N_STAGES - 1;
    localparam logic [3:0]           c_last_stage     = c_last_stage_int[3:0];
    localparam int                   c_dl_last        = BF_LATENCY - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;

    // Delay line; entry 0 captures the read pair, the last entry feeds the
    // registered write ports on the following edge.
    logic                  r_dl_valid  [BF_LATENCY];
    logic [ADDR_WIDTH-1:0] r_dl_addr_0 [BF_LATENCY];
    logic [ADDR_WIDTH-1:0] r_dl_addr_1 [BF_LATENCY];
    logic                  r_dl_sel    [BF_LATENCY];
    logic [3:0]            r_dl_stage  [BF_LATENCY];

    logic [N_STEPS-1:0]    r_pair_cnt;
    logic [3:0]            r_stage_cnt;
    logic [c_acc_w-1:0]    r_acc_cnt;

    logic                  r_wr_en_a;
    logic                  r_wr_en_b;
    logic [ADDR_WIDTH-1:0] r_wr_addr_0;
    logic [ADDR_WIDTH-1:0] r_wr_addr_1;
    logic [3:0]            r_wr_stage;
    logic                  r_stage_done;
    logic                  r_fft_done;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_write;
    logic                  w_all_accepted;
    logic                  w_last_of_stage;
    logic                  w_last_write;
    logic                  w_stage_mismatch;

    assign w_write          = r_dl_valid[c_dl_last];
    assign w_all_accepted   = (r_acc_cnt == c_total_pairs);
    assign w_last_of_stage  = (r_pair_cnt == c_last_pair);
    assign w_last_write     = w_last_of_stage && (r_stage_cnt == c_last_stage);
    assign w_stage_mismatch = (r_dl_stage[c_dl_last] != r_stage_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pair_cnt   <= '0;
            r_stage_cnt  <= '0;
            r_acc_cnt    <= '0;
            r_wr_en_a    <= 1'b0;
            r_wr_en_b    <= 1'b0;
            r_wr_addr_0  <= '0;
            r_wr_addr_1  <= '0;
            r_wr_stage   <= '0;
            r_stage_done <= 1'b0;
            r_fft_done   <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                r_dl_valid[i]  <= 1'b0;
                r_dl_addr_0[i] <= '0;
                r_dl_addr_1[i] <= '0;
                r_dl_sel[i]    <= 1'b0;
                r_dl_stage[i]  <= '0;
            end
        end else begin
            r_wr_en_a    <= 1'b0;
            r_wr_en_b    <= 1'b0;
            r_stage_done <= 1'b0;

            // Shift every cycle so bubbles travel through untouched; entry 0
            // only becomes valid when a pair is accepted below.
            for (int i = BF_LATENCY - 1; i > 0; i--) begin
                r_dl_valid[i]  <= r_dl_valid[i-1];
                r_dl_addr_0[i] <= r_dl_addr_0[i-1];
                r_dl_addr_1[i] <= r_dl_addr_1[i-1];
                r_dl_sel[i]    <= r_dl_sel[i-1];
                r_dl_stage[i]  <= r_dl_stage[i-1];
            end
            r_dl_valid[0]  <= 1'b0;
            r_dl_addr_0[0] <= bus.rd_addr_0;
            r_dl_addr_1[0] <= bus.rd_addr_1;
            r_dl_sel[0]    <= bus.rd_ram_select;
            r_dl_stage[0]  <= bus.rd_stage;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // Pairs outside a transform are dropped and flagged.
                    if (bus.rd_valid) begin
                        r_err <= 1'b1;
                    end
                    // Start overrides the error raised in the same cycle.
                    if (bus.start) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_fft_done  <= 1'b0;
                        r_err       <= 1'b0;
                        r_pair_cnt  <= '0;
                        r_stage_cnt <= '0;
                        r_acc_cnt   <= '0;
                        for (int i = 0; i < BF_LATENCY; i++) begin
                            r_dl_valid[i] <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (bus.rd_valid) begin
                        if (w_all_accepted) begin
                            r_err <= 1'b1;
                        end else begin
                            r_dl_valid[0] <= 1'b1;
                            r_acc_cnt     <= r_acc_cnt + 1'b1;
                        end
                    end

                    if (w_write) begin
                        // Select 1 means the pair was read from A: results go to B.
                        r_wr_en_b   <= r_dl_sel[c_dl_last];
                        r_wr_en_a   <= ~r_dl_sel[c_dl_last];
                        r_wr_addr_0 <= r_dl_addr_0[c_dl_last];
                        r_wr_addr_1 <= r_dl_addr_1[c_dl_last];
                        r_wr_stage  <= r_dl_stage[c_dl_last];
                        r_pair_cnt  <= r_pair_cnt + 1'b1;
                        if (w_stage_mismatch) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_of_stage) begin
                            r_stage_cnt  <= r_stage_cnt + 4'd1;
                            r_stage_done <= 1'b1;
                        end
                        if (w_last_write) begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_fft_done <= 1'b1;
                            // Anything still in flight belongs to no transform.
                            for (int i = 0; i < BF_LATENCY; i++) begin
                                r_dl_valid[i] <= 1'b0;
                            end
                        end
                    end
                    // start is deliberately ignored while running.
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_en_a    = r_wr_en_a;
    assign bus.wr_en_b    = r_wr_en_b;
    assign bus.wr_addr_0  = r_wr_addr_0;
    assign bus.wr_addr_1  = r_wr_addr_1;
    assign bus.wr_stage   = r_wr_stage;
    assign bus.stage_done = r_stage_done;
    assign bus.fft_done   = r_fft_done;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: doc/fft_writeback_ctrl.md
# fft_writeback_ctrl

Write-back address controller for the in-place radix-2 FFT; it is the write end of the butterfly address stream. It captures each read-address pair issued by the address generator and delays it through a pipeline matching the butterfly latency. It then writes the butterfly results to the opposite ping-pong RAM at the same address pair. It counts completed writes per stage and per transform, and raises stage and transform completion only once the last result has been written.

## Interface
- addr_width, 10: RAM address width.
- n_steps, 9: log2 of butterflies per stage (512 pairs per stage).
- n_stages, 10: stages per transform.
- bf_latency, 3: butterfly pipeline depth in cycles; legal range 1..15.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE or DONE.
- rd_valid  in  1  a read-address pair is issued this cycle.
- rd_addr_0  in  addr_width  lower read address of the pair.
- rd_addr_1  in  addr_width  upper read address of the pair.
- rd_ram_select  in  1  1: read from RAM A, 0: read from RAM B.
- rd_stage  in  4  stage index tagged on the pair.
- wr_en_a  out  1  write both addresses of the pair into RAM A.
- wr_en_b  out  1  write both addresses of the pair into RAM B.
- wr_addr_0  out  addr_width  lower write address.
- wr_addr_1  out  addr_width  upper write address.
- wr_stage  out  4  stage index of the current write.
- stage_done  out  1  one-cycle pulse on the last write of a stage.
- fft_done  out  1  level; high from the last write of the transform until the next start or rst.
- busy  out  1  high in RUN.
- err  out  1  sticky error; cleared by start or rst.

## Operation
- FSM states:
  - IDLE, entered on reset.
  - IDLE or DONE goes to RUN when start is high. This clears the counters, delay line and err, and drives fft_done low.
  - RUN goes to DONE on the cycle that issues write number n_stages·2^n_steps.
  - start is ignored while in RUN.
- Delay line:
  - bf_latency entries, each holding {valid, addr_0, addr_1, select, stage}.
  - A pair is loaded only when rd_valid is high and the state is RUN.
  - The output entry drives the write ports.
  - Bubbles in rd_valid are preserved exactly.
- RAM steering: a delayed select of 1 asserts wr_en_b; a delayed select of 0 asserts wr_en_a. wr_en_a and wr_en_b are never high together.
- Write addresses equal the read addresses, unmodified (in-place algorithm).
- Counters:
  - pair_cnt has n_steps bits and increments on each write.
  - stage_cnt has 4 bits. It increments when pair_cnt wraps from 2^n_steps−1 to 0, and stage_done pulses on that same write.
- Error conditions, each of which sets err:
  - the delayed stage tag differs from stage_cnt at write time;
  - rd_valid is high in IDLE or DONE (the pair is dropped);
  - rd_valid is high in RUN after 2^n_steps·n_stages pairs have been accepted (the pair is dropped).
- When err is set, writes continue unchanged.
- Entering DONE clears any pairs still in the delay line; none remain if the input stream is legal.

## Timing
- Reset values:
  - wr_en_a, wr_en_b, stage_done, fft_done, busy, err are 0.
  - wr_addr_0, wr_addr_1, wr_stage are 0.
  - The delay line is invalid and the counters are 0.
- Latency: a pair sampled with rd_valid at edge t appears on the write ports (with its wr_en high) from edge t+bf_latency.
- Write outputs are registered.
- The write, stage_done, fft_done rising edge and the RUN→DONE transition all occur in the same cycle.
- busy rises the cycle after start is sampled. It falls in the same cycle fft_done rises.
- rst in mid-operation takes effect at the next edge: state returns to IDLE and in-flight pairs are discarded with no write.
- start sampled in the same cycle as a rd_valid in DONE: the pair is dropped and err is set, then err is cleared by the start. Start has priority, so err ends at 0.

## Test plan
- Single pair, bf_latency=3: start, then rd_valid at edge t with addr_0=4, addr_1=5, sel=1, stage=0. Required: wr_en_b=1, wr_addr_0=4, wr_addr_1=5 exactly at t+3 for one cycle, and wr_en_a=0.
- Full transform: 10×512 continuous pairs. Required:
  - stage_done pulses exactly 10 times;
  - writes alternate B, A, B… per stage;
  - fft_done rises on write 5120, 3 cycles after the last rd_valid;
  - busy falls on that same cycle.
- Bubbles: the pattern 1,0,0,1,1 on rd_valid. Required: the identical pattern on wr_en, shifted by 3 cycles, with pair_cnt advancing only on writes.
- Reset mid-run: rst asserted two cycles after a rd_valid. Required: no write emitted, all outputs 0, state IDLE, and a subsequent start runs a clean transform.
- Stage mismatch: the pair tagged stage=1 while stage_cnt=0. Required: the write still occurs, err=1 from the write cycle and held until the next start.
- Illegal input: rd_valid in IDLE, and start asserted during RUN. Required: no write for the IDLE pair and err=1. The start is ignored, with counters and busy unchanged.
